// File: rtl/mchan_resp_router_pkg.sv
// Shared types and width helpers for the mchan response router and its per-port FIFO.
// Optional feature macro: MCHAN_RESP_ROUTER_ERR_EN (sticky out-of-range-ID flag plus assertions).
package mchan_resp_router_pkg;

    // State fields are sized for the largest supported FIFO (DEPTH <= 255).
    localparam int unsigned FIFO_STATE_W = 8;

    typedef logic [FIFO_STATE_W-1:0] fifo_field_t;

    typedef struct packed {
        fifo_field_t rd_ptr;
        fifo_field_t wr_ptr;
        fifo_field_t count;
    } fifo_state_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mchan_resp_fifo.sv
// Single-clock per-port response FIFO: push/full on one side, pop/empty with head data on the other.
// With MCHAN_RESP_ROUTER_ERR_EN defined, a push into a full FIFO trips an assertion.
module mchan_resp_fifo
    import mchan_resp_router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  full_o,
    input  logic                  pop_i,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int unsigned PW       = ptr_w(DEPTH);
    localparam fifo_field_t LAST_PTR = fifo_field_t'(DEPTH - 1);
    localparam fifo_field_t FULL_CNT = fifo_field_t'(DEPTH);
    localparam fifo_field_t ONE      = fifo_field_t'(1);

    fifo_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  do_push, do_pop;

    assign full_o  = (state_q.count == FULL_CNT);
    assign empty_o = (state_q.count == '0);
    assign data_o  = mem_q[state_q.rd_ptr[PW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[state_q.wr_ptr[PW-1:0]] = data_i;
            state_d.wr_ptr = (state_q.wr_ptr == LAST_PTR) ? '0 : state_q.wr_ptr + ONE;
        end
        if (do_pop) begin
            state_d.rd_ptr = (state_q.rd_ptr == LAST_PTR) ? '0 : state_q.rd_ptr + ONE;
        end
        // Simultaneous push and pop leaves the occupancy untouched.
        if (do_push && !do_pop) begin
            state_d.count = state_q.count + ONE;
        end else if (do_pop && !do_push) begin
            state_d.count = state_q.count - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef MCHAN_RESP_ROUTER_ERR_EN
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));
`endif

endmodule

// File: rtl/mchan_resp_router.sv
// 1-to-N response router: decodes id_i, pushes the beat into that port's FIFO, grants unless it is full.
// MCHAN_RESP_ROUTER_ERR_EN enables the sticky err_o flag and the out-of-range-ID assertion.
module mchan_resp_router
    import mchan_resp_router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_MASTER   = 2,
    parameter int unsigned LOG_MASTER = (N_MASTER == 1) ? 1 : $clog2(N_MASTER),
    parameter int unsigned DEPTH      = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_i,
    output logic                                 gnt_o,
    input  logic [DATA_WIDTH-1:0]                data_i,
    input  logic [LOG_MASTER-1:0]                id_i,
    output logic [N_MASTER-1:0]                  req_o,
    input  logic [N_MASTER-1:0]                  gnt_i,
    output logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_o,
    output logic                                 err_o
);

    localparam logic [LOG_MASTER:0] N_M = (LOG_MASTER + 1)'(N_MASTER);

    logic                in_range;
    logic                full_sel;
    logic [N_MASTER-1:0] sel, push, full, empty;

    assign in_range = ({1'b0, id_i} < N_M);

    always_comb begin
        sel      = '0;
        full_sel = 1'b0;
        for (int p = 0; p < N_MASTER; p++) begin
            if (id_i == LOG_MASTER'(p)) begin
                sel[p]   = 1'b1;
                full_sel = full[p];
            end
        end
        // Grant looks only at the registered full flag, never at this cycle's pop.
        gnt_o = in_range ? !full_sel : 1'b1;
        push  = (req_i && gnt_o) ? sel : '0;
    end

    for (genvar p = 0; p < N_MASTER; p++) begin : g_port
        mchan_resp_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[p]),
            .data_i  (data_i),
            .full_o  (full[p]),
            .pop_i   (gnt_i[p]),
            .empty_o (empty[p]),
            .data_o  (data_o[p])
        );
        assign req_o[p] = !empty[p];
    end

`ifdef MCHAN_RESP_ROUTER_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (req_i && !in_range);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    a_id_in_range: assert property (@(posedge clk) disable iff (!rst_n) req_i |-> in_range);
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mchan_resp_router.sv
// Scoreboard bench for mchan_resp_router (N_MASTER=3, DEPTH=2): per-port expected queues checked on negedge.
module tb_mchan_resp_router;

    localparam int DW    = 32;
    localparam int NM    = 3;
    localparam int LM    = 2;
    localparam int DEPTH = 2;
`ifdef MCHAN_RESP_ROUTER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     req_i = 1'b0;
    logic                     gnt_o;
    logic [DW-1:0]            data_i = '0;
    logic [LM-1:0]            id_i = '0;
    logic [NM-1:0]            req_o;
    logic [NM-1:0]            gnt_i = '0;
    logic [NM-1:0][DW-1:0]    data_o;
    logic                     err_o;

    mchan_resp_router #(
        .DATA_WIDTH (DW),
        .N_MASTER   (NM),
        .LOG_MASTER (LM),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req_i),
        .gnt_o  (gnt_o),
        .data_i (data_i),
        .id_i   (id_i),
        .req_o  (req_o),
        .gnt_i  (gnt_i),
        .data_o (data_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-port expected beats and occupancy, sticky error.
    logic [DW-1:0] exp_q [NM][$];
    int            mcnt  [NM];
    bit            err_exp = 1'b0;
    bit            mon_en  = 1'b0;
    bit            gexp;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("err_o", {63'd0, err_o}, {63'd0, err_exp});
            for (int p = 0; p < NM; p++) begin
                chk($sformatf("req_o[%0d]", p), {63'd0, req_o[p]}, {63'd0, (mcnt[p] != 0)});
                if (mcnt[p] != 0)
                    chk($sformatf("data_o[%0d]", p), {32'd0, data_o[p]}, {32'd0, exp_q[p][0]});
            end
            gexp = (int'(id_i) < NM) ? (mcnt[id_i] < DEPTH) : 1'b1;
            chk("gnt_o", {63'd0, gnt_o}, {63'd0, gexp});
            if (!rst_n) begin
                for (int p = 0; p < NM; p++) begin
                    exp_q[p].delete();
                    mcnt[p] = 0;
                end
                err_exp = 1'b0;
            end else begin
                for (int p = 0; p < NM; p++) begin
                    if (mcnt[p] != 0 && gnt_i[p]) begin
                        void'(exp_q[p].pop_front());
                        mcnt[p]--;
                    end
                end
                if (req_i && gexp) begin
                    if (int'(id_i) < NM) begin
                        exp_q[id_i].push_back(data_i);
                        mcnt[id_i]++;
                    end else if (ERR_EN) begin
                        err_exp = 1'b1;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [DW-1:0] d);
        req_i  = 1'b1;
        id_i   = LM'(id);
        data_i = d;
        cyc();
        req_i  = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < NM; p++) mcnt[p] = 0;
        cyc(); cyc();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_req_o", {61'd0, req_o}, 64'd0);
        chk("rst_err_o", {63'd0, err_o}, 64'd0);
        cyc();

        // Single beat, held until the port accepts it.
        send(2, 32'hA5A5_0001);
        @(negedge clk);
        chk("t1_req_o", {61'd0, req_o}, 64'b100);
        chk("t1_data", {32'd0, data_o[2]}, 64'hA5A5_0001);
        cyc(); cyc();
        gnt_i[2] = 1'b1;
        cyc();
        gnt_i = '0;
        @(negedge clk);
        chk("t1_drain", {61'd0, req_o}, 64'd0);
        cyc();

        // Fill port 1; the third beat is refused, then drain in order.
        send(1, 32'h1);
        send(1, 32'h2);
        id_i = LM'(1);
        @(negedge clk);
        chk("t2_full_gnt", {63'd0, gnt_o}, 64'd0);
        send(1, 32'h3);
        gnt_i[1] = 1'b1;
        cyc(); cyc(); cyc();
        gnt_i = '0;

        // Port 0 full and stalled; ports 1 and 2 still flow.
        send(0, 32'h100);
        send(0, 32'h101);
        send(1, 32'h200);
        send(2, 32'h300);
        cyc();
        gnt_i = '1;
        cyc(); cyc(); cyc();

        // Streaming into port 0 with its grant held high.
        gnt_i = 3'b001;
        for (int i = 0; i < 16; i++) begin
            req_i  = 1'b1;
            id_i   = '0;
            data_i = DW'(i);
            cyc();
        end
        req_i = 1'b0;
        cyc(); cyc();
        gnt_i = '0;

        // Out-of-range destination: granted and dropped.
        send(3, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("oor_req_o", {61'd0, req_o}, 64'd0);
        chk("oor_err_o", {63'd0, err_o}, {63'd0, ERR_EN});
        cyc();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            req_i  = 1'($urandom_range(0, 1));
            id_i   = LM'($urandom_range(0, ERR_EN ? 2 : 3));
            data_i = $urandom;
            gnt_i  = NM'($urandom_range(0, 7));
            cyc();
        end
        req_i = 1'b0;
        gnt_i = '0;

        // Reset with beats buffered on every port.
        send(0, 32'hAA0);
        send(1, 32'hAA1);
        send(2, 32'hAA2);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_req_o", {61'd0, req_o}, 64'd0);
        chk("mrst_err_o", {63'd0, err_o}, 64'd0);
        cyc();
        send(1, 32'hBEE1);
        @(negedge clk);
        chk("mrst_lat", {61'd0, req_o}, 64'b010);
        chk("mrst_data", {32'd0, data_o[1]}, 64'hBEE1);
        gnt_i = '1;
        cyc(); cyc();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
